// File: rtl/pattern_classifier_pkg.sv
// pattern_classifier_pkg
//   Shared types and constants for the pattern classifier.
//   - rule_t   : one table entry {value, mask, en}. Value and mask are held at
//                RULE_W bits; a classifier instance uses the low DATA_W bits and
//                keeps the upper bits at zero, so one type serves every width
//                up to RULE_W.
//   - MISS_IDX : rule index reported when no enabled rule matches.
//   - rule_match : casez-style compare, mask bit 1 = compared, 0 = wildcard.
package pattern_classifier_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int NUM_RULES_DEF = 4;
  localparam int CNT_W_DEF     = 16;

  // Widest classified word supported by the shared rule type.
  localparam int RULE_W        = 32;

  localparam int MISS_IDX      = 0;

  typedef struct packed {
    logic [RULE_W-1:0] value;
    logic [RULE_W-1:0] mask;
    logic              en;
  } rule_t;

  function automatic logic rule_match(input logic [RULE_W-1:0] word,
                                      input rule_t             rule);
    return rule.en && (((word ^ rule.value) & rule.mask) == '0);
  endfunction

endpackage

// File: rtl/prio_match.sv
// prio_match
//   Combinational priority matcher. Compares one word against every rule of
//   the table and reports the lowest-index enabled rule that matches.
//   Ports:
//     word  in   RULE_W             word to classify (zero-extended)
//     rules in   NUM_RULES x rule_t rule table
//     hit   out  1                  some enabled rule matched
//     idx   out  IDX_W              winning rule index, MISS_IDX on miss
module prio_match
  import pattern_classifier_pkg::*;
#(
  parameter int NUM_RULES = NUM_RULES_DEF,
  parameter int IDX_W     = $clog2(NUM_RULES + 1)
) (
  input  logic [RULE_W-1:0]           word,
  input  rule_t [NUM_RULES-1:0]       rules,
  output logic                        hit,
  output logic [IDX_W-1:0]            idx
);

  // Scan from the highest index down so the lowest matching index is the
  // last assignment and therefore wins.
  always_comb begin
    hit = 1'b0;
    idx = IDX_W'(MISS_IDX);
    for (int r = NUM_RULES - 1; r >= 0; r--) begin
      if (rule_match(word, rules[r])) begin
        hit = 1'b1;
        idx = IDX_W'(r);
      end
    end
  end

endmodule

// File: rtl/pattern_classifier.sv
// pattern_classifier
//   Streaming word classifier feeding a case/casez decode stage. Every word
//   accepted on the input handshake is matched against a programmable table
//   of value/care-mask rules (lowest index wins) and presented one cycle
//   later, with its classification, on a registered output handshake.
//   Saturating per-rule hit counters plus a miss counter are kept for debug.
//   Ports:
//     clk, rst_n            clock, synchronous active-low reset
//     cfg_we/idx/value/mask/en  rule write port (idx >= NUM_RULES ignored)
//     in_valid/in_ready/in_data input handshake
//     out_valid/out_ready       output handshake
//     out_data/out_hit/out_idx  word passed through plus classification
//     cnt_sel/cnt_clr/cnt_value counter read-back (NUM_RULES = miss counter)
module pattern_classifier
  import pattern_classifier_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NUM_RULES = NUM_RULES_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int IDX_W     = $clog2(NUM_RULES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [DATA_W-1:0] cfg_value,
  input  logic [DATA_W-1:0] cfg_mask,
  input  logic              cfg_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_hit,
  output logic [IDX_W-1:0]  out_idx,
  input  logic [IDX_W-1:0]  cnt_sel,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_value
);

  localparam int NUM_CNT = NUM_RULES + 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  rule_t [NUM_RULES-1:0] rules;
  logic  [CNT_W-1:0]     cnt_q [NUM_CNT];

  logic                  accept_p0;
  logic                  hit_p0;
  logic [IDX_W-1:0]      idx_p0;
  logic [IDX_W-1:0]      cnt_tgt_p0;

  logic                  vld_p1;
  logic [DATA_W-1:0]     data_p1;
  logic                  hit_p1;
  logic [IDX_W-1:0]      idx_p1;

  // ---- stage p0: handshake and classification against the current table ----
  // in_ready depends only on registered state and out_ready, so there is no
  // combinational path from in_valid to any output.
  assign in_ready  = !vld_p1 || out_ready;
  assign accept_p0 = in_valid && in_ready;

  prio_match #(
    .NUM_RULES (NUM_RULES),
    .IDX_W     (IDX_W)
  ) u_prio_match (
    .word  (RULE_W'(in_data)),
    .rules (rules),
    .hit   (hit_p0),
    .idx   (idx_p0)
  );

  assign cnt_tgt_p0 = hit_p0 ? idx_p0 : IDX_W'(NUM_RULES);

  // Rule table. A write lands at the edge, so a word accepted in the same
  // cycle was already classified against the previous contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_RULES; r++) begin
        rules[r] <= '0;
      end
    end else if (cfg_we) begin
      for (int r = 0; r < NUM_RULES; r++) begin
        if (cfg_idx == IDX_W'(r)) begin
          rules[r].value <= RULE_W'(cfg_value);
          rules[r].mask  <= RULE_W'(cfg_mask);
          rules[r].en    <= cfg_en;
        end
      end
    end
  end

  // ---- stage p1: registered output, held while stalled ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      hit_p1  <= 1'b0;
      idx_p1  <= IDX_W'(MISS_IDX);
    end else if (accept_p0) begin
      vld_p1  <= 1'b1;
      data_p1 <= in_data;
      hit_p1  <= hit_p0;
      idx_p1  <= idx_p0;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_hit   = hit_p1;
  assign out_idx   = idx_p1;

  // Hit/miss counters, updated with the accept. Clear takes priority over a
  // simultaneous increment.
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (accept_p0) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (cnt_tgt_p0 == IDX_W'(i)) begin
          cnt_q[i] <= sat_inc(cnt_q[i]);
        end
      end
    end
  end

  // Read-back mux; selects past the miss counter read as zero.
  always_comb begin
    cnt_value = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (cnt_sel == IDX_W'(i)) begin
        cnt_value = cnt_q[i];
      end
    end
  end

endmodule
